s2mm_ring_addresser: RTL and testbench
======================================

Name: s2mm_ring_addresser

Overview:
- Stage directly upstream of the S2MM RAM writer.
- Accepts the raw sample AXI-Stream and re-emits it with a per-beat byte address that walks a software-configured ring buffer in DDR.
- Stops only on burst boundaries, so the writer always receives whole bursts whose first beat carries a burst-aligned address.
- Publishes a write pointer and a wrap counter so software can locate the newest complete data.

Parameters:
ADDR_WIDTH, 32, width of cfg_base, cfg_length, address, write_ptr
AXIS_TDATA_WIDTH, 32, stream data width
BURST_BEATS, 16, beats per downstream burst; must match writer burst length
BYTES_PER_BEAT, 4, address increment per beat (AXI data width / 8)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
cfg_base  in  ADDR_WIDTH  ring start byte address; must be aligned to BURST_BEATS*BYTES_PER_BEAT
cfg_length  in  ADDR_WIDTH  ring size in bytes; non-zero multiple of BURST_BEATS*BYTES_PER_BEAT
cfg_enable  in  1  run request, level sensitive
S_AXIS_tdata  in  AXIS_TDATA_WIDTH  input samples
S_AXIS_tvalid  in  1  input valid
S_AXIS_tready  out  1  input ready
M_AXIS_tdata  out  AXIS_TDATA_WIDTH  samples to writer
M_AXIS_tvalid  out  1  output valid
M_AXIS_tready  in  1  writer ready
address  out  ADDR_WIDTH  byte address of the current M_AXIS beat; valid while M_AXIS_tvalid=1
write_ptr  out  ADDR_WIDTH  offset just past the last fully handed-off burst
wrap_count  out  16  number of ring wraps since start; modulo 2^16
running  out  1  1 in RUN or DRAIN
cfg_error  out  1  sticky; set on an invalid config at start
dropped  out  16  beats discarded while IDLE; saturates at 0xFFFF

Behaviour:
- Reset values: all outputs 0; state IDLE; offset 0; skid buffer empty.
- State IDLE:
  - S_AXIS_tready=1; accepted beats are discarded and increment dropped.
  - On cfg_enable=1, latch cfg_base and cfg_length.
  - If the config is valid: clear offset, write_ptr, wrap_count, dropped and cfg_error; go to RUN.
  - If the config is invalid (length 0, length not a multiple of the burst size, or base not burst-aligned): set cfg_error and stay IDLE. The check is re-evaluated every cycle while cfg_enable=1.
- State RUN:
  - Beats pass through a 2-entry skid buffer.
  - S_AXIS_tready = buffer not full. The registered ready is deasserted when the second entry fills.
  - Latency from S handshake to M_AXIS_tvalid is 1 cycle.
  - Full throughput, one beat per cycle, while M_AXIS_tready=1.
- Address tagging:
  - Each accepted beat is tagged with address = base_l + offset. The tag travels with the data through the skid buffer.
  - Offset is then advanced: if offset + BYTES_PER_BEAT == length_l, offset becomes 0 and wrap_count increments; otherwise offset increases by BYTES_PER_BEAT.
  - Arithmetic is ADDR_WIDTH wide. No carry beyond base_l + length_l is possible for a valid config.
- Beat counting:
  - A beat-in-burst counter, clog2(BURST_BEATS) bits, counts accepted beats.
  - A second counter tracks output handshakes. On the last beat of a burst (M handshake), write_ptr is set to that beat's offset + BYTES_PER_BEAT, wrapped to 0 at length_l.
- cfg_enable deasserted in RUN:
  - If the input beat counter is 0, go to DRAIN with no further input accepted.
  - Otherwise go to DRAIN and keep accepting until the input beat counter wraps to 0.
- State DRAIN:
  - Input is accepted only while beats are owed to the current burst.
  - Once the burst is complete and the skid buffer is empty, go to IDLE.
  - cfg_enable=1 during DRAIN returns to RUN without re-latching config or clearing counters.
- Simultaneous events: a wrap and the last beat of a burst in the same cycle both take effect. write_ptr becomes 0 and wrap_count increments.
- Config changes are ignored outside IDLE.
- aresetn low at any time, including mid-burst:
  - Returns to reset values next edge and flushes the skid buffer.
  - The downstream writer is reset by the same aresetn.
- running=1 exactly in RUN and DRAIN.

Test Plan:
- Basic sequence: base=0x1000_0000, length=0x400, enable, 32 continuous beats with tready=1 -> addresses 0x1000_0000..0x1000_007C step 4; write_ptr=0x40 then 0x80; first output 1 cycle after first input.
- Wrap: length=0x40, 20 beats -> beat 16 address=0x1000_0000 again; wrap_count=1; write_ptr=0x00 after beat 16.
- Backpressure: M_AXIS_tready random 50%, 64 beats -> no beat lost or duplicated; address/data pairs intact; S_AXIS_tready low within 1 cycle of skid full.
- Drain: deassert enable after 5 beats -> exactly 11 more beats accepted; M output carries 16 beats; then IDLE, running=0; further input dropped with dropped counting 1, 2, ...
- Invalid config: length=0x30 or base=0x1000_0004, enable -> cfg_error=1, running=0, no M_AXIS_tvalid; fix config -> cfg_error cleared, RUN.
- Reset mid-burst: aresetn low at beat 7 -> next cycle all outputs 0, M_AXIS_tvalid=0; after re-enable addresses restart at base.

Source files
------------

// File: rtl/s2mm_ring_addresser.sv
// rtl/s2mm_ring_addresser.sv - tags an AXI-Stream with ring-buffer byte addresses, stopping only on burst boundaries
module s2mm_ring_addresser #(
    parameter int ADDR_WIDTH       = 32,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BURST_BEATS      = 16,
    parameter int BYTES_PER_BEAT   = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ADDR_WIDTH-1:0]       cfg_base,
    input  logic [ADDR_WIDTH-1:0]       cfg_length,
    input  logic                        cfg_enable,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic [ADDR_WIDTH-1:0]       address,
    output logic [ADDR_WIDTH-1:0]       write_ptr,
    output logic [15:0]                 wrap_count,
    output logic                        running,
    output logic                        cfg_error,
    output logic [15:0]                 dropped
);

    // Burst size in bytes is assumed to be a power of two, so alignment is a mask test.
    localparam int                    BURST_BYTES = BURST_BEATS * BYTES_PER_BEAT;
    localparam int                    CNT_W       = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BURST_MASK  = ADDR_WIDTH'(BURST_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_INC    = ADDR_WIDTH'(BYTES_PER_BEAT);
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BURST_BEATS - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched ring geometry and published status
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_offset;
    logic [ADDR_WIDTH-1:0] r_write_ptr;
    logic [15:0]           r_wrap_count;
    logic                  r_cfg_error;
    logic [15:0]           r_dropped;

    // Beat-in-burst counters on the accept side and the hand-off side
    logic [CNT_W-1:0]      r_in_cnt;
    logic [CNT_W-1:0]      r_out_cnt;

    // Registered input ready, computed one cycle ahead from next-state values
    logic                  r_s_ready;
    logic                  w_s_ready_next;

    // Two-entry skid buffer; each entry carries the data and its ring offset
    logic [AXIS_TDATA_WIDTH-1:0] r_buf_data [0:1];
    logic [ADDR_WIDTH-1:0]       r_buf_off  [0:1];
    logic                        r_wr_sel;
    logic                        r_rd_sel;
    logic [1:0]                  r_fill;
    logic [1:0]                  w_fill_next;

    logic                  w_cfg_valid;
    logic                  w_s_hs;
    logic                  w_accept;
    logic                  w_m_valid;
    logic                  w_m_hs;
    logic                  w_in_last;
    logic                  w_out_last;
    logic [CNT_W-1:0]      w_in_cnt_next;
    logic [ADDR_WIDTH-1:0] w_off_inc;
    logic                  w_off_wrap;
    logic [ADDR_WIDTH-1:0] w_head_off;
    logic [ADDR_WIDTH-1:0] w_head_inc;
    logic [ADDR_WIDTH-1:0] w_wp_next;

    assign w_cfg_valid = (cfg_length != '0)
                      && ((cfg_length & BURST_MASK) == '0)
                      && ((cfg_base & BURST_MASK) == '0);

    assign w_s_hs     = S_AXIS_tvalid && r_s_ready;
    assign w_accept   = w_s_hs && (r_state != ST_IDLE);
    assign w_m_valid  = (r_fill != 2'd0);
    assign w_m_hs     = w_m_valid && M_AXIS_tready;

    assign w_in_last  = (r_in_cnt == LAST_BEAT);
    assign w_out_last = (r_out_cnt == LAST_BEAT);
    assign w_in_cnt_next = !w_accept ? r_in_cnt
                         : (w_in_last ? '0 : r_in_cnt + CNT_ONE);

    assign w_off_inc  = r_offset + BEAT_INC;
    assign w_off_wrap = (w_off_inc == r_len);

    // write_ptr points just past the burst's last beat, folded back to 0 at the ring end
    assign w_head_off = r_buf_off[r_rd_sel];
    assign w_head_inc = w_head_off + BEAT_INC;
    assign w_wp_next  = (w_head_inc == r_len) ? '0 : w_head_inc;

    // Skid buffer occupancy after this cycle's accept and hand-off
    always_comb begin
        w_fill_next = r_fill;
        case ({w_accept, w_m_hs})
            2'b10:   w_fill_next = r_fill + 2'd1;
            2'b01:   w_fill_next = r_fill - 2'd1;
            default: w_fill_next = r_fill;
        endcase
    end

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, and the input ready that the next state will present
    always_comb begin
        w_state_next   = r_state;
        w_s_ready_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_enable && w_cfg_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!cfg_enable) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cfg_enable) begin
                    w_state_next = ST_RUN;
                end else if ((r_in_cnt == '0) && (r_out_cnt == '0) && (r_fill == 2'd0)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // DRAIN only takes beats still owed to the burst already started
        case (w_state_next)
            ST_IDLE:  w_s_ready_next = 1'b1;
            ST_RUN:   w_s_ready_next = (w_fill_next != 2'd2);
            ST_DRAIN: w_s_ready_next = (w_fill_next != 2'd2) && (w_in_cnt_next != '0);
            default:  w_s_ready_next = 1'b0;
        endcase
    end

    // Input ready register; held low through reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_s_ready <= 1'b0;
        end else begin
            r_s_ready <= w_s_ready_next;
        end
    end

    // Config latch, ring offset, burst counters and status outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_base       <= '0;
            r_len        <= '0;
            r_offset     <= '0;
            r_write_ptr  <= '0;
            r_wrap_count <= '0;
            r_cfg_error  <= 1'b0;
            r_dropped    <= '0;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
        end else if (r_state == ST_IDLE) begin
            if (cfg_enable) begin
                r_base <= cfg_base;
                r_len  <= cfg_length;
            end
            if (cfg_enable && w_cfg_valid) begin
                r_offset     <= '0;
                r_write_ptr  <= '0;
                r_wrap_count <= '0;
                r_dropped    <= '0;
                r_cfg_error  <= 1'b0;
                r_in_cnt     <= '0;
                r_out_cnt    <= '0;
            end else begin
                if (cfg_enable) begin
                    r_cfg_error <= 1'b1;
                end
                if (w_s_hs && (r_dropped != 16'hFFFF)) begin
                    r_dropped <= r_dropped + 16'd1;
                end
            end
        end else begin
            if (w_accept) begin
                if (w_off_wrap) begin
                    r_offset     <= '0;
                    r_wrap_count <= r_wrap_count + 16'd1;
                end else begin
                    r_offset <= w_off_inc;
                end
            end
            r_in_cnt <= w_in_cnt_next;
            if (w_m_hs) begin
                r_out_cnt <= w_out_last ? '0 : r_out_cnt + CNT_ONE;
                if (w_out_last) begin
                    r_write_ptr <= w_wp_next;
                end
            end
        end
    end

    // Skid buffer storage and pointers; reset flushes it
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_off[0]  <= '0;
            r_buf_off[1]  <= '0;
            r_wr_sel      <= 1'b0;
            r_rd_sel      <= 1'b0;
            r_fill        <= 2'd0;
        end else begin
            if (w_accept) begin
                r_buf_data[r_wr_sel] <= S_AXIS_tdata;
                r_buf_off[r_wr_sel]  <= r_offset;
                r_wr_sel             <= ~r_wr_sel;
            end
            if (w_m_hs) begin
                r_rd_sel <= ~r_rd_sel;
            end
            r_fill <= w_fill_next;
        end
    end

    assign S_AXIS_tready = r_s_ready;
    assign M_AXIS_tvalid = w_m_valid;
    assign M_AXIS_tdata  = r_buf_data[r_rd_sel];
    assign address       = r_base + w_head_off;
    assign write_ptr     = r_write_ptr;
    assign wrap_count    = r_wrap_count;
    assign running       = (r_state != ST_IDLE);
    assign cfg_error     = r_cfg_error;
    assign dropped       = r_dropped;

endmodule

// File: tb/tb_s2mm_ring_addresser.sv
// tb/tb_s2mm_ring_addresser.sv - scoreboard bench for s2mm_ring_addresser
module tb_s2mm_ring_addresser;

    logic        aclk;
    logic        aresetn;
    logic [31:0] cfg_base;
    logic [31:0] cfg_length;
    logic        cfg_enable;
    logic [31:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid;
    logic        S_AXIS_tready;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tready;
    logic [31:0] address;
    logic [31:0] write_ptr;
    logic [15:0] wrap_count;
    logic        running;
    logic        cfg_error;
    logic [15:0] dropped;

    s2mm_ring_addresser #(
        .ADDR_WIDTH       (32),
        .AXIS_TDATA_WIDTH (32),
        .BURST_BEATS      (16),
        .BYTES_PER_BEAT   (4)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_base      (cfg_base),
        .cfg_length    (cfg_length),
        .cfg_enable    (cfg_enable),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (S_AXIS_tready),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .address       (address),
        .write_ptr     (write_ptr),
        .wrap_count    (wrap_count),
        .running       (running),
        .cfg_error     (cfg_error),
        .dropped       (dropped)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] off;
    } beat_t;

    beat_t       sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference ring model
    logic [31:0] mdl_base;
    logic [31:0] mdl_len;
    logic [31:0] mdl_off;
    logic [31:0] exp_wp;
    logic [31:0] exp_wrap;
    int          mdl_out_cnt;

    logic        track  = 1'b0;
    logic        sb_en  = 1'b0;
    logic        chk_rdy = 1'b0;
    logic        bp_en  = 1'b0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Writer-side ready: random under backpressure, otherwise always ready
    initial begin
        M_AXIS_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            M_AXIS_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares status against the model, then applies the handshakes of the coming edge
    initial begin
        beat_t b;
        forever begin
            @(negedge aclk);
            if (track) begin
                check("write_ptr", write_ptr, exp_wp);
                check("wrap_count", 32'(wrap_count), exp_wrap);
                check("m_valid", 32'(M_AXIS_tvalid), 32'(sb_q.size() != 0));
                if (chk_rdy) begin
                    check("s_ready", 32'(S_AXIS_tready), 32'(sb_q.size() < 2));
                end
                if (M_AXIS_tvalid && M_AXIS_tready && (sb_q.size() != 0)) begin
                    b = sb_q.pop_front();
                    check("m_data", M_AXIS_tdata, b.data);
                    check("m_addr", address, b.addr);
                    if (mdl_out_cnt == 15) begin
                        mdl_out_cnt = 0;
                        exp_wp = (b.off + 32'd4 == mdl_len) ? 32'd0 : b.off + 32'd4;
                    end else begin
                        mdl_out_cnt++;
                    end
                end
                if (S_AXIS_tvalid && S_AXIS_tready && sb_en) begin
                    b.data = S_AXIS_tdata;
                    b.off  = mdl_off;
                    b.addr = mdl_base + mdl_off;
                    sb_q.push_back(b);
                    if (mdl_off + 32'd4 == mdl_len) begin
                        mdl_off  = 32'd0;
                        exp_wrap = exp_wrap + 32'd1;
                    end else begin
                        mdl_off = mdl_off + 32'd4;
                    end
                end
            end
        end
    end

    task automatic start(input logic [31:0] base, input logic [31:0] len);
        cfg_base   = base;
        cfg_length = len;
        cfg_enable = 1'b1;
        @(posedge aclk);
        #1;
        sb_q.delete();
        mdl_base    = base;
        mdl_len     = len;
        mdl_off     = 32'd0;
        exp_wp      = 32'd0;
        exp_wrap    = 32'd0;
        mdl_out_cnt = 0;
        track   = 1'b1;
        sb_en   = 1'b1;
        chk_rdy = 1'b1;
        check("start_cfg_error", 32'(cfg_error), 32'd0);
        check("start_running", 32'(running), 32'd1);
    endtask

    task automatic send(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            S_AXIS_tdata  = $urandom;
            S_AXIS_tvalid = 1'b1;
            @(negedge aclk);
            while (!S_AXIS_tready && guard < 200) begin
                guard++;
                @(negedge aclk);
            end
            if (!S_AXIS_tready) begin
                check("send_ready", 32'(S_AXIS_tready), 32'd1);
                S_AXIS_tvalid = 1'b0;
                return;
            end
            @(posedge aclk);
            #1;
        end
        S_AXIS_tvalid = 1'b0;
    endtask

    task automatic wait_empty();
        int guard;
        guard = 0;
        @(negedge aclk);
        while (sb_q.size() != 0 && guard < 1000) begin
            guard++;
            @(negedge aclk);
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        @(posedge aclk);
        #1;
    endtask

    // Drop enable, expect exactly n more beats accepted, then a return to IDLE
    task automatic drain(input int n);
        cfg_enable = 1'b0;
        chk_rdy    = 1'b0;
        @(posedge aclk);
        #1;
        send(n);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = $urandom;
        @(negedge aclk);
        check("drain_stop", 32'(S_AXIS_tready), 32'd0);
        @(posedge aclk);
        #1;
        S_AXIS_tvalid = 1'b0;
        sb_en = 1'b0;
        wait_empty();
        repeat (2) @(posedge aclk);
        #1;
        check("drain_idle", 32'(running), 32'd0);
        track = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        aresetn       = 1'b0;
        cfg_base      = '0;
        cfg_length    = '0;
        cfg_enable    = 1'b0;
        S_AXIS_tdata  = '0;
        S_AXIS_tvalid = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        check("rst_s_ready", 32'(S_AXIS_tready), 32'd0);
        check("rst_m_valid", 32'(M_AXIS_tvalid), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_address", address, 32'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("idle_s_ready", 32'(S_AXIS_tready), 32'd1);

        // Invalid length, then fixed
        cfg_base   = 32'h1000_0000;
        cfg_length = 32'h30;
        cfg_enable = 1'b1;
        @(posedge aclk);
        #1;
        check("badlen_error", 32'(cfg_error), 32'd1);
        check("badlen_running", 32'(running), 32'd0);
        @(posedge aclk);
        #1;
        check("badlen_m_valid", 32'(M_AXIS_tvalid), 32'd0);

        // Basic 32-beat run
        start(32'h1000_0000, 32'h400);
        send(1);
        check("first_latency", 32'(M_AXIS_tvalid), 32'd1);
        check("first_addr", address, 32'h1000_0000);
        send(31);
        wait_empty();
        check("basic_wp", write_ptr, 32'h80);
        drain(0);

        // Ring wrap with a 64-byte ring
        start(32'h1000_0000, 32'h40);
        send(20);
        wait_empty();
        check("wrap_count1", 32'(wrap_count), 32'd1);
        check("wrap_wp", write_ptr, 32'd0);
        drain(12);
        check("wrap_count2", 32'(wrap_count), 32'd2);

        // Drain mid-burst, then dropped beats in IDLE
        start(32'h1000_0000, 32'h400);
        send(5);
        drain(11);
        check("drain_wp", write_ptr, 32'h40);
        check("dropped0", 32'(dropped), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            send(1);
            check("dropped_cnt", 32'(dropped), 32'(k));
            check("idle_m_valid", 32'(M_AXIS_tvalid), 32'd0);
        end

        // Misaligned base
        cfg_base   = 32'h1000_0004;
        cfg_length = 32'h400;
        cfg_enable = 1'b1;
        @(posedge aclk);
        #1;
        check("badbase_error", 32'(cfg_error), 32'd1);
        check("badbase_running", 32'(running), 32'd0);

        // Random writer backpressure
        start(32'h2000_0000, 32'h400);
        bp_en = 1'b1;
        send(64);
        wait_empty();
        bp_en = 1'b0;
        check("bp_wp", write_ptr, 32'h100);
        drain(0);

        // Reset in the middle of a burst
        start(32'h1000_0000, 32'h400);
        send(7);
        aresetn = 1'b0;
        track   = 1'b0;
        sb_en   = 1'b0;
        chk_rdy = 1'b0;
        @(posedge aclk);
        #1;
        check("mrst_m_valid", 32'(M_AXIS_tvalid), 32'd0);
        check("mrst_s_ready", 32'(S_AXIS_tready), 32'd0);
        check("mrst_m_data", M_AXIS_tdata, 32'd0);
        check("mrst_address", address, 32'd0);
        check("mrst_wp", write_ptr, 32'd0);
        check("mrst_wrap", 32'(wrap_count), 32'd0);
        check("mrst_running", 32'(running), 32'd0);
        check("mrst_error", 32'(cfg_error), 32'd0);
        check("mrst_dropped", 32'(dropped), 32'd0);
        cfg_enable = 1'b0;
        aresetn    = 1'b1;
        @(posedge aclk);
        #1;
        start(32'h1000_0000, 32'h400);
        send(1);
        check("restart_addr", address, 32'h1000_0000);
        send(2);
        wait_empty();
        drain(13);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
